// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
// The HALT state exists only when MC_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    // Immediate format depends only on the opcode, independent of FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM's ALUOp and the instruction funct fields to the ALU operation.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_ALUOp,
    input  logic [2:0] i_funct3,
    input  logic       i_OpCode5,
    input  logic       i_funct7_5,
    output logic [2:0] o_ALUControl
);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        o_ALUControl = ALU_ADD;
        case (i_ALUOp)
            ALUOP_SUB: o_ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // funct7[5] selects sub only for R-type; for addi it is immediate bits
                    F3_ADDSUB: o_ALUControl = (i_OpCode5 & i_funct7_5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:    o_ALUControl = ALU_SLT;
                    F3_OR:     o_ALUControl = ALU_OR;
                    F3_AND:    o_ALUControl = ALU_AND;
                    default:   o_ALUControl = ALU_ADD;
                endcase
            end
            default: o_ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (lw, sw, R/I ALU, beq, jal) with memory-ready stalls.
// Define MC_ILLEGAL_TRAP_EN to trap illegal opcodes in a HALT state; otherwise they run as NOPs.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_OpCode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    input  logic       i_Zero,
    input  logic       i_MemReady,
    output logic       o_PCWrite,
    output logic       o_IRWrite,
    output logic       o_MemWrite,
    output logic       o_RegWrite,
    output logic       o_AdrSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ImmSrc,
    output logic [2:0] o_ALUControl,
    output logic       o_InstrDone,
    output logic       o_Illegal
);

    state_t     r_state;
    state_t     w_state;
    state_t     w_next_state;
    logic [1:0] w_alu_op;
    logic       w_branch;
    logic       w_pc_update;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_done;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       w_illegal;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // While in reset the selects show FETCH values; enables are gated separately below.
    assign w_state = i_Reset ? S_FETCH : r_state;

    always_comb begin
        w_next_state = w_state;
        o_AdrSrc     = 1'b0;
        o_ALUSrcA    = SRCA_PC;
        o_ALUSrcB    = SRCB_RS2;
        o_ResultSrc  = RES_ALUOUT;
        w_alu_op     = ALUOP_ADD;
        w_branch     = 1'b0;
        w_pc_update  = 1'b0;
        w_irwrite    = 1'b0;
        w_memwrite   = 1'b0;
        w_regwrite   = 1'b0;
        w_done       = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
        w_illegal    = 1'b0;
`endif
        case (w_state)
            S_FETCH: begin
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALU;
                if (i_MemReady) begin
                    w_irwrite    = 1'b1;
                    w_pc_update  = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
                case (i_OpCode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECUTER;
                    OP_ITYPE:          w_next_state = S_EXECUTEI;
                    OP_BRANCH:         w_next_state = S_BEQ;
                    OP_JAL:            w_next_state = S_JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        w_next_state = S_HALT;
`else
                        w_next_state = S_FETCH;
                        w_done       = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                o_ALUSrcA    = SRCA_RS1;
                o_ALUSrcB    = SRCB_IMM;
                w_next_state = (i_OpCode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                o_AdrSrc = 1'b1;
                if (i_MemReady) begin
                    w_next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                o_ResultSrc  = RES_DATA;
                w_regwrite   = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                o_AdrSrc   = 1'b1;
                w_memwrite = 1'b1;
                if (i_MemReady) begin
                    w_done       = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_EXECUTER: begin
                o_ALUSrcA    = SRCA_RS1;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_ALUSrcA    = SRCA_RS1;
                o_ALUSrcB    = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite   = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQ: begin
                o_ALUSrcA    = SRCA_RS1;
                w_alu_op     = ALUOP_SUB;
                w_branch     = 1'b1;
                w_done       = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                // PC takes the DECODE-computed target while the ALU forms PC+4 for rd
                o_ALUSrcA    = SRCA_OLDPC;
                o_ALUSrcB    = SRCB_FOUR;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: begin
                w_illegal    = 1'b1;
                w_next_state = S_HALT;
            end
`endif
            default: w_next_state = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_ALUOp      (w_alu_op),
        .i_funct3     (i_funct3),
        .i_OpCode5    (i_OpCode[5]),
        .i_funct7_5   (i_funct7_5),
        .o_ALUControl (o_ALUControl)
    );

    assign o_ImmSrc    = imm_src_of(i_OpCode);
    assign o_PCWrite   = ~i_Reset & (w_pc_update | (w_branch & i_Zero));
    assign o_IRWrite   = ~i_Reset & w_irwrite;
    assign o_MemWrite  = ~i_Reset & w_memwrite;
    assign o_RegWrite  = ~i_Reset & w_regwrite;
    assign o_InstrDone = ~i_Reset & w_done;
`ifdef MC_ILLEGAL_TRAP_EN
    assign o_Illegal   = ~i_Reset & w_illegal;
`else
    assign o_Illegal   = 1'b0;
`endif

endmodule
